// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  // Step counter must reach 2*w.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  // Saturation values; each also equals the largest quotient magnitude representable in w bits.
  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] sat_uns(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/div_sub.sv
// Trial subtractor for one restoring-division step: a - b in WIDTH+1 bits.
module div_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH-1:0] diff,
  output logic             nonneg
);

  logic [WIDTH:0] full;

  assign full   = a - b;
  assign diff   = full[WIDTH-1:0];
  assign nonneg = ~full[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, 2W/W -> W quotient and remainder, one bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0]   dvs,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic               dbz
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

`ifdef DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));
`else
  localparam logic [WIDTH-1:0] SAT_U = WIDTH'(sat_uns(WIDTH));
`endif

  state_t state, state_nx;

  logic [WIDTH-1:0]   r;
  logic [2*WIDTH-1:0] q;
  logic [WIDTH-1:0]   dvs_mag;
  logic               dvd_neg, quo_neg, zero_div;
  logic [CW-1:0]      cnt;

  logic               dvd_sign, dvs_sign;
  logic [2*WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH-1:0]   t;
  logic               t_ok;
  logic [WIDTH-1:0]   sat, fix_quo, fix_rem;
  logic               fix_ovf, fix_dbz;

  // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_sign = dvd[2*WIDTH-1];
    dvs_sign = dvs[WIDTH-1];
`else
    dvd_sign = 1'b0;
    dvs_sign = 1'b0;
`endif
    dvd_abs = dvd_sign ? -dvd : dvd;
    dvs_abs = dvs_sign ? -dvs : dvs;
  end

  // One step shifts {R,Q} left; the MSB of Q enters R.
  assign r_sh = {r, q[2*WIDTH-1]};

  div_sub #(.WIDTH(WIDTH)) u_sub (
    .a      (r_sh),
    .b      ({1'b0, dvs_mag}),
    .diff   (t),
    .nonneg (t_ok)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (dvs == '0) ? FIX : ITER;
      ITER:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r        <= '0;
      q        <= '0;
      dvs_mag  <= '0;
      dvd_neg  <= 1'b0;
      quo_neg  <= 1'b0;
      zero_div <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r        <= '0;
          cnt      <= '0;
          dvs_mag  <= dvs_abs;
          dvd_neg  <= dvd_sign;
          quo_neg  <= dvd_sign ^ dvs_sign;
          zero_div <= (dvs == '0);
          // Divide by zero skips ITER; Q keeps the raw dividend for the remainder output.
          q        <= (dvs == '0) ? dvd : dvd_abs;
        end
        ITER: begin
          r   <= t_ok ? t : r_sh[WIDTH-1:0];
          q   <= {q[2*WIDTH-2:0], t_ok};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    sat = quo_neg ? SAT_N : SAT_P;
`else
    sat = SAT_U;
`endif
    fix_ovf = q > {{WIDTH{1'b0}}, sat};
    fix_dbz = 1'b0;
    fix_quo = quo_neg ? -q[WIDTH-1:0] : q[WIDTH-1:0];
    fix_rem = dvd_neg ? -r : r;
    if (fix_ovf) begin
      fix_quo = sat;
      fix_rem = '0;
    end
    if (zero_div) begin
      fix_quo = '1;
      fix_rem = q[WIDTH-1:0];
      fix_ovf = 1'b0;
      fix_dbz = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo  <= '0;
      rem  <= '0;
      ovf  <= 1'b0;
      dbz  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        quo <= fix_quo;
        rem <= fix_rem;
        ovf <= fix_ovf;
        dbz <= fix_dbz;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; expectations follow DIVIDER_SIGNED_EN.
module tb_seq_divider;

  localparam int W = 8;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*W-1:0] dvd   = '0;
  logic [W-1:0]   dvs   = '0;
  logic [W-1:0]   quo, rem;
  logic           busy, done, ovf, dbz;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dvd   (dvd),
    .dvs   (dvs),
    .quo   (quo),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           o;
    string          name;
  } vec_t;

  // Starts one operation from an idle cycle and waits (bounded) for done.
  // A second start with different operands is pulsed before edge poke_at when poke_at > 0.
  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input int poke_at,
                        output int lat, output bit busy_ok, output bit held_ok);
    logic [W-1:0] q0, r0;
    logic         o0, z0;
    q0 = quo; r0 = rem; o0 = ovf; z0 = dbz;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    lat     = -1;
    dvd = a; dvs = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == poke_at) begin
        dvd = ~a; dvs = b + 8'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (quo !== q0 || rem !== r0 || ovf !== o0 || dbz !== z0) held_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dvd = 16'h1234; dvs = 8'h05; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quo !== 8'h00) begin failures++; $display("FAIL reset_quo got=%h exp=00", quo); end
    checks++; if (rem !== 8'h00) begin failures++; $display("FAIL reset_rem got=%h exp=00", rem); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divide();
    vec_t vecs[7];
    int   lat;
    bit   busy_ok, held_ok;
`ifdef DIVIDER_SIGNED_EN
    vecs[0] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, "pos_by_pos"};
    vecs[1] = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, "neg_by_pos"};
    vecs[2] = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, "pos_by_neg"};
    vecs[3] = '{16'hFF00, 8'h02, 8'h80, 8'h00, 1'b0, "neg_limit"};
    vecs[4] = '{16'h1000, 8'h02, 8'h7F, 8'h00, 1'b1, "pos_ovf"};
    vecs[5] = '{16'h01FE, 8'h02, 8'h7F, 8'h00, 1'b1, "pos_ovf_255"};
    vecs[6] = '{16'hFEFE, 8'h02, 8'h80, 8'h00, 1'b1, "neg_ovf_129"};
`else
    vecs[0] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, "small"};
    vecs[1] = '{16'hFF9C, 8'h07, 8'hFF, 8'h00, 1'b1, "big_ovf"};
    vecs[2] = '{16'h0064, 8'hF9, 8'h00, 8'h64, 1'b0, "zero_quo"};
    vecs[3] = '{16'hFF00, 8'h02, 8'hFF, 8'h00, 1'b1, "ff00_ovf"};
    vecs[4] = '{16'h1000, 8'h02, 8'hFF, 8'h00, 1'b1, "1000_ovf"};
    vecs[5] = '{16'h01FE, 8'h02, 8'hFF, 8'h00, 1'b0, "max_quo"};
    vecs[6] = '{16'hFEFE, 8'h02, 8'hFF, 8'h00, 1'b1, "fefe_ovf"};
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, lat, busy_ok, held_ok);
      checks++; if (lat != 17) begin failures++; $display("FAIL %s latency got=%0d exp=17", vecs[i].name, lat); end
      checks++; if (quo !== vecs[i].q) begin failures++; $display("FAIL %s quo got=%h exp=%h", vecs[i].name, quo, vecs[i].q); end
      checks++; if (rem !== vecs[i].r) begin failures++; $display("FAIL %s rem got=%h exp=%h", vecs[i].name, rem, vecs[i].r); end
      checks++; if (ovf !== vecs[i].o) begin failures++; $display("FAIL %s ovf got=%b exp=%b", vecs[i].name, ovf, vecs[i].o); end
      checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL %s dbz got=%b exp=0", vecs[i].name, dbz); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b exp=0", vecs[i].name, busy); end
      checks++; if (!busy_ok) begin failures++; $display("FAIL %s busy_during_op got=0 exp=1", vecs[i].name); end
      checks++; if (!held_ok) begin failures++; $display("FAIL %s outputs_held got=changed exp=held", vecs[i].name); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", vecs[i].name, done); end
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    bit busy_ok, held_ok;
    run_op(16'h1234, 8'h00, 0, lat, busy_ok, held_ok);
    checks++; if (lat != 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL dbz_ovf got=%b exp=0", ovf); end
    checks++; if (quo !== 8'hFF) begin failures++; $display("FAIL dbz_quo got=%h exp=ff", quo); end
    checks++; if (rem !== 8'h34) begin failures++; $display("FAIL dbz_rem got=%h exp=34", rem); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dbz_busy got=%b exp=0", busy); end
    run_op(16'hFF9C, 8'h00, 0, lat, busy_ok, held_ok);
    checks++; if (lat != 1) begin failures++; $display("FAIL dbz_neg_latency got=%0d exp=1", lat); end
    checks++; if (rem !== 8'h9C) begin failures++; $display("FAIL dbz_neg_rem got=%h exp=9c", rem); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL dbz_after got=done%b/busy%b exp=done0/busy0", done, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit busy_ok, held_ok;
    dvd = 16'h0064; dvs = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got=busy%b/done%b exp=busy0/done0", busy, done);
    end
    checks++; if (quo !== 8'h00 || rem !== 8'h00) begin
      failures++; $display("FAIL midrst_data got=%h/%h exp=00/00", quo, rem);
    end
    checks++; if (ovf !== 1'b0 || dbz !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got=ovf%b/dbz%b exp=ovf0/dbz0", ovf, dbz);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", done); end
    run_op(16'h0064, 8'h07, 0, lat, busy_ok, held_ok);
    checks++; if (lat != 17) begin failures++; $display("FAIL postrst_latency got=%0d exp=17", lat); end
    checks++; if (quo !== 8'h0E || rem !== 8'h02) begin
      failures++; $display("FAIL postrst_result got=%h/%h exp=0e/02", quo, rem);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    bit busy_ok, held_ok;
    run_op(16'h0064, 8'h07, 4, lat, busy_ok, held_ok);
    checks++; if (lat != 17) begin failures++; $display("FAIL ignore_latency got=%0d exp=17", lat); end
    checks++; if (quo !== 8'h0E || rem !== 8'h02) begin
      failures++; $display("FAIL ignore_result got=%h/%h exp=0e/02", quo, rem);
    end
    checks++; if (!busy_ok) begin failures++; $display("FAIL ignore_busy got=0 exp=1"); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit busy_ok, held_ok;
    logic [W-1:0] exp_q;
    logic         exp_o;
`ifdef DIVIDER_SIGNED_EN
    exp_q = 8'h7F; exp_o = 1'b1;
`else
    exp_q = 8'hFF; exp_o = 1'b0;
`endif
    run_op(16'h0064, 8'h07, 0, lat, busy_ok, held_ok);
    checks++; if (lat != 17) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=17", lat); end
    // Second start is driven in the done cycle of the first.
    run_op(16'h01FE, 8'h02, 0, lat, busy_ok, held_ok);
    checks++; if (lat != 17) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=17", lat); end
    checks++; if (quo !== exp_q || rem !== 8'h00 || ovf !== exp_o) begin
      failures++; $display("FAIL b2b_second_result got=%h/%h/%b exp=%h/00/%b", quo, rem, ovf, exp_q, exp_o);
    end
    checks++; if (!held_ok) begin failures++; $display("FAIL b2b_held got=changed exp=held"); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%b exp=0", done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divide();
    test_div_by_zero();
    test_reset_mid_op();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: 2W-bit dividend ÷ W-bit divisor → W-bit quotient and W-bit remainder, one quotient bit per clock. It is the inverse companion of the team's sequential Booth 8x8 multiplier and uses the same start/busy handshake. A 16-bit product from the multiplier can be fed straight back in as the dividend.

## Interface
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  load operands and begin; sampled only when busy=0
- dvd  in  2*WIDTH  dividend
- dvs  in  WIDTH  divisor
- quo  out  WIDTH  quotient, registered, held until next result
- rem  out  WIDTH  remainder, registered, held until next result
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when quo/rem/flags are updated
- ovf  out  1  quotient not representable in WIDTH bits (valid with done, held)
- dbz  out  1  divide by zero (valid with done, held)

## Operation
- Reset behaviour: rst_n=0 at any edge (including mid-operation) → state IDLE, busy=0, done=0, quo=0, rem=0, ovf=0, dbz=0. Any in-flight operation is discarded.
- States:
  - IDLE: start=1 → ITER, or FIX if dvs==0.
  - ITER: runs 2*WIDTH steps, then → FIX.
  - FIX: always → IDLE.
- Load (IDLE with start=1):
  - Latch magnitudes |dvd| and |dvs|, the sign of dvd and the sign of the quotient (sign(dvd) XOR sign(dvs)).
  - Partial remainder R (WIDTH+1 bits) := 0; shift register Q := |dvd|; step counter := 0.
- Step (ITER, per cycle):
  - Shift {R,Q} left by 1.
  - Trial T = R − {0,|dvs|}, computed in WIDTH+1 bits.
  - If T ≥ 0: R := T and Q[0] := 1.
  - Counter increments; leave ITER after step 2*WIDTH.
- FIX:
  - Q holds the 2W-bit magnitude quotient; R[W-1:0] holds the magnitude remainder.
  - Negate the quotient if the quotient sign is set.
  - Negate the remainder if dvd was negative (truncating division; the remainder takes the dividend's sign).
  - Overflow test: ovf=1 if the magnitude exceeds 2^(W-1)−1 for a positive quotient, or 2^(W-1) for a negative one. On overflow, quo saturates to 0x7F or 0x80 (W=8) and rem=0.
  - Divide by zero: dbz=1, ovf=0, quo=all ones, rem=dvd[W-1:0].
  - Register quo, rem, ovf and dbz; done=1.
- start while busy=1: ignored; operands are not re-sampled.
- Operands must be held stable only in the start cycle.

## Timing
- Start sampled at edge 0. busy=1 after edge 0 and through all of ITER.
- Normal operation: steps at edges 1..2W, FIX at edge 2W+1. With W=8, done=1 and busy=0 after edge 17, so latency is 17 cycles.
- Divide by zero: FIX at edge 1, so done is visible after edge 1.
- done is high for exactly one cycle. busy=0 in that same cycle, so a start in the done cycle is accepted (back-to-back operation).
- Flags and results change only at the done edge or at reset.

## Configuration
- DIVIDER_SIGNED_EN defined: two's-complement operands, with the sign handling and signed overflow rules above.
- DIVIDER_SIGNED_EN undefined: operands are unsigned and no negation is performed. ovf=1 when the quotient exceeds 2^W−1; on overflow quo saturates to all ones and rem=0. Divide-by-zero behaviour and timing are identical.

## Structure
- Package divider_pkg holds:
  - state enum (IDLE, ITER, FIX)
  - default WIDTH
  - step-counter width $clog2(2*WIDTH+1)
  - saturation constants
- One sub-module, div_sub: combinational (WIDTH+1)-bit trial subtractor returning difference and sign (non-negative) flag. It is instantiated once in ITER datapath.

## Test plan
- Signed, dvd=0x0064, dvs=0x07 → after 17 cycles: done pulse, quo=0x0E, rem=0x02, ovf=0, dbz=0.
- Signed, dvd=0xFF9C (−100), dvs=0x07 → quo=0xF2 (−14), rem=0xFE (−2).
- Quotient limits:
  - dvd=0xFF00, dvs=0x02 → quo=0x80, ovf=0.
  - dvd=0x1000, dvs=0x02 → ovf=1, quo=0x7F, rem=0x00.
- dvs=0x00, dvd=0x1234 → done after 1 cycle, dbz=1, quo=0xFF, rem=0x34, busy never held beyond that cycle.
- Reset and back-to-back:
  - rst_n=0 at step 5 → busy, done and all outputs 0 next cycle.
  - A new start then completes normally.
  - start asserted in the done cycle → second result 17 cycles later.
  - start pulsed mid-operation → ignored.
- Unsigned build, dvd=0xFF00, dvs=0x02 → ovf=1, quo=0xFF. With dvd=0x01FE, dvs=0x02 → quo=0xFF, rem=0x00.
